mem_write_fsm: RTL and testbench
================================

MEM_WRITE_FSM -- requirements
Module: mem_write_fsm

Interface
REQ-001 Parameter N_SENS, default 8, number of ToF sensors (each with one ToF_dr bit).
REQ-002 Parameter ZONES, default 64, zone words per sensor per frame; the zone address is carried in the sensor data, not generated here.
REQ-003 Parameter IDX_W, default 3, width of ToF_Index, equal to clog2(N_SENS).
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 ToF_dr  input  N_SENS  per-sensor one-cycle pulse: sensor i holds a new valid zone word on the shared data bus.
REQ-007 ToF_Index  output  IDX_W  registered sensor select, driving the data-bus mux and the BRAM address MSBs.
REQ-008 wea  output  1  BRAM write enable; high for exactly one cycle per accepted word.
REQ-009 all_data_written  output  1  one-cycle pulse: every sensor has delivered ZONES words since the last pulse or reset.

Function
REQ-010 Pending: pending[i] SHALL set on ToF_dr[i]=1 and clear when sensor i's WRITE cycle completes.
- A set and a clear of the same bit in one cycle: the set wins.
REQ-011 FSM states: IDLE and WRITE.
- IDLE -> WRITE when any pending bit is set; otherwise stay in IDLE.
- WRITE -> IDLE unconditionally after one cycle.
REQ-012 On IDLE->WRITE, ToF_Index SHALL load the granted sensor, chosen round-robin.
- Search ascending modulo N_SENS, starting at last-served+1.
- The search pointer is 0 after reset.
REQ-013 wea SHALL equal (state==WRITE); ToF_Index is stable for the whole WRITE cycle.
REQ-014 Latency: ToF_dr[i] pulse sampled at edge t, no contention -> pending[i] at t+1 -> WRITE with wea=1 during cycle t+1..t+2.
- Peak throughput is one write per 2 cycles.
REQ-015 Each completed WRITE for sensor i increments a counter cnt[i] of width clog2(ZONES)+1.
- On reaching ZONES, done[i] SHALL set and cnt[i] SHALL saturate.
REQ-016 Words from a sensor with done[i]=1 SHALL still be written (wea pulse) but SHALL NOT change cnt or done.
REQ-017 When all done bits are set, all_data_written SHALL pulse high for the cycle after the completing WRITE.
- In that same cycle, all cnt and done SHALL clear.
REQ-018 A ToF_dr[i] pulse while pending[i] is already set and not being cleared that cycle is an overrun.
- The word is lost; only one write occurs.

Reset
REQ-019 On reset=1 at a clock edge, the following SHALL be 0 on the next cycle: state=IDLE, pending, cnt, done, round-robin pointer, ToF_Index, wea, all_data_written.
REQ-020 Reset asserted during WRITE SHALL drop wea the following cycle; the aborted word is not counted.
REQ-021 ToF_dr is ignored while reset is high.

Configuration
REQ-022 Macro MEM_WRITE_OVERRUN_FLAG_EN defined:
- Adds output port overrun (1 bit).
- overrun is sticky high from the cycle after any REQ-018 event until reset.
- Undefined: the port and its logic are absent; overruns are silently dropped.

Structure
REQ-023 Package mem_write_pkg SHALL hold the N_SENS, ZONES and IDX_W defaults and the state enum type (IDLE, WRITE).
REQ-024 The round-robin grant logic SHALL be a sub-module rr_arbiter, combinational, with pending and pointer in and grant index and valid out.

Verification
REQ-025 Single pulse ToF_dr=8'h04 at edge t -> ToF_Index=2 and wea=1 during cycle t+1..t+2, then wea=0.
REQ-026 ToF_dr=8'hFF in one cycle -> 8 writes, indices 0..7 in order, wea high every other cycle.
REQ-027 64 pulses from each of the 8 sensors (512 writes) -> exactly one all_data_written pulse, one cycle after the 512th write; cnt and done read 0 afterwards.
REQ-028 Sensor 3 sends 65 words, the others 64 -> 513 wea pulses, one all_data_written pulse.
REQ-029 ToF_dr[5] pulsed on two consecutive cycles while the FSM is busy -> one write for sensor 5; with MEM_WRITE_OVERRUN_FLAG_EN, overrun=1 until reset.
REQ-030 reset asserted in a WRITE cycle -> wea=0 and ToF_Index=0 the next cycle, and no all_data_written pulse.

Source files
------------

// File: rtl/mem_write_pkg.sv
// -----------------------------------------------------------------------------
// mem_write_pkg
//
// Shared definitions for the ToF-to-BRAM write sequencer:
//   DEF_N_SENS  default number of ToF sensors (one data-ready bit each)
//   DEF_ZONES   default number of zone words each sensor delivers per frame
//   DEF_IDX_W   default width of the sensor select, clog2(DEF_N_SENS)
//   state_t     two-state sequencer encoding (IDLE, WRITE)
//   wrap_inc    modulo increment used to advance the round-robin pointer
// -----------------------------------------------------------------------------
package mem_write_pkg;

  localparam int DEF_N_SENS = 8;
  localparam int DEF_ZONES  = 64;
  localparam int DEF_IDX_W  = 3;

  // IDLE waits for any pending sensor; WRITE is the single BRAM write cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // Advance an index by one and wrap back to zero at n, so the
  // round-robin search always resumes just after the sensor last served.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//
// Purely combinational round-robin grant. Scans the pending vector upwards,
// modulo N_SENS, starting at the pointer position, and returns the first
// requesting sensor.
//
// Ports:
//   pending  in   N_SENS  one bit per sensor with a word waiting
//   pointer  in   IDX_W   first index to examine (last served + 1)
//   grant    out  IDX_W   index of the selected sensor (0 when none)
//   valid    out  1       high when at least one pending bit is set
// -----------------------------------------------------------------------------
module rr_arbiter
  import mem_write_pkg::*;
#(
  parameter int N_SENS = DEF_N_SENS,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic [N_SENS-1:0] pending,
  input  logic [IDX_W-1:0]  pointer,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  logic [IDX_W-1:0] cand;

  // Walk every offset from the pointer; the first pending candidate wins
  // and later hits are ignored because valid is already set.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_SENS; k++) begin
      cand = IDX_W'((int'(pointer) + k) % N_SENS);
      if (!valid && pending[cand]) begin
        valid = 1'b1;
        grant = cand;
      end
    end
  end

endmodule

// File: rtl/mem_write_fsm.sv
// -----------------------------------------------------------------------------
// mem_write_fsm
//
// Collects one-cycle data-ready pulses from N_SENS time-of-flight sensors,
// serialises them onto a single BRAM write port with a round-robin grant,
// and tracks how many zone words each sensor has delivered in the current
// frame. Once every sensor has delivered ZONES words a one-cycle
// all_data_written pulse is raised and the per-sensor counters restart.
//
// Ports:
//   clk               in   1       single clock, rising edge
//   reset             in   1       synchronous, active-high
//   ToF_dr            in   N_SENS  per-sensor "new zone word on the bus" pulse
//   ToF_Index         out  IDX_W   registered sensor select (data mux and
//                                  BRAM address MSBs)
//   wea               out  1       BRAM write enable, one cycle per word
//   all_data_written  out  1       one-cycle frame-complete pulse
//   overrun           out  1       sticky lost-word flag (only when the
//                                  MEM_WRITE_OVERRUN_FLAG_EN macro is defined)
//
// Build option:
//   MEM_WRITE_OVERRUN_FLAG_EN  adds the overrun output. Without it a pulse
//                              that arrives while the same sensor is still
//                              waiting is silently merged into that request.
// -----------------------------------------------------------------------------
module mem_write_fsm
  import mem_write_pkg::*;
#(
  parameter int N_SENS = DEF_N_SENS,
  parameter int ZONES  = DEF_ZONES,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SENS-1:0] ToF_dr,
  output logic [IDX_W-1:0]  ToF_Index,
  output logic              wea,
  output logic              all_data_written
`ifdef MEM_WRITE_OVERRUN_FLAG_EN
  ,
  output logic              overrun
`endif
);

  localparam int CNT_W = $clog2(ZONES) + 1;

  state_t            state;
  state_t            state_next;
  logic              load_grant;

  logic [N_SENS-1:0] pending;
  logic [N_SENS-1:0] pending_next;
  logic [N_SENS-1:0] sel_mask;
  logic [N_SENS-1:0] clear_mask;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;

  logic [CNT_W-1:0]  cnt [N_SENS];
  logic [N_SENS-1:0] done;
  logic              write_active;
  logic              count_hit;
  logic              reaches_zones;
  logic              frame_done;

  // Round-robin selection among the sensors that currently hold a word.
  rr_arbiter #(
    .N_SENS (N_SENS),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .pending (pending),
    .pointer (rr_ptr),
    .grant   (grant_idx),
    .valid   (grant_valid)
  );

  // Sequencer next state and write enable. A grant is only taken from IDLE,
  // so every write is followed by one IDLE cycle in which the arbiter sees
  // the cleared pending bit; that bounds throughput at one word per two
  // cycles but keeps ToF_Index stable across the whole WRITE cycle.
  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    wea        = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = WRITE;
          load_grant = 1'b1;
        end
      end
      WRITE: begin
        wea        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending bookkeeping. The bit for the sensor being written is released at
  // the end of its WRITE cycle; a fresh pulse in that very cycle re-arms it,
  // so the new word is queued rather than lost.
  always_comb begin
    write_active = (state == WRITE);
    sel_mask     = {{(N_SENS-1){1'b0}}, 1'b1} << ToF_Index;
    clear_mask   = write_active ? sel_mask : '0;
    pending_next = (pending & ~clear_mask) | ToF_dr;
  end

  // Frame accounting for the write now completing. Sensors that already hit
  // ZONES are written to memory but not counted again. The frame closes when
  // the word that brings the last outstanding sensor up to ZONES is written.
  always_comb begin
    count_hit     = write_active && !done[ToF_Index];
    reaches_zones = count_hit && (cnt[ToF_Index] == CNT_W'(ZONES - 1));
    frame_done    = reaches_zones && (&(done | sel_mask));
  end

  // State register, pending vector, sensor select and round-robin pointer.
  // The pointer moves only when a grant is taken, so the next search starts
  // one past the sensor that was just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      ToF_Index <= '0;
      rr_ptr    <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      if (load_grant) begin
        ToF_Index <= grant_idx;
        rr_ptr    <= IDX_W'(wrap_inc(int'(grant_idx), N_SENS));
      end
    end
  end

  // Per-sensor word counters and completion flags. A counter stops at ZONES
  // because its done bit blocks further counting. On frame completion all
  // counters and flags restart together while the frame pulse is raised.
  // A WRITE cut short by reset never reaches the counting branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SENS; i++) begin
        cnt[i] <= '0;
      end
      done             <= '0;
      all_data_written <= 1'b0;
    end else begin
      all_data_written <= frame_done;
      if (frame_done) begin
        for (int i = 0; i < N_SENS; i++) begin
          cnt[i] <= '0;
        end
        done <= '0;
      end else if (count_hit) begin
        cnt[ToF_Index] <= cnt[ToF_Index] + CNT_W'(1);
        if (reaches_zones) begin
          done[ToF_Index] <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_WRITE_OVERRUN_FLAG_EN
  logic [N_SENS-1:0] overrun_hits;

  // A pulse lands on a sensor whose previous word is still waiting and is
  // not being released this cycle: the earlier word gets overwritten on the
  // shared bus, so only one write results.
  always_comb begin
    overrun_hits = ToF_dr & pending & ~clear_mask;
  end

  // Sticky lost-word indicator, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (|overrun_hits) begin
      overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_write_fsm.sv
// -----------------------------------------------------------------------------
// tb_mem_write_fsm
//
// Self-checking bench for mem_write_fsm with default parameters. A cycle
// level reference model keeps queued sensors, a rotating service order and
// per-sensor word totals, and every cycle the DUT outputs are compared
// against it. Directed scenarios cover single pulses, full bursts, complete
// frames, an extra word, overruns and reset during a write, followed by
// random traffic.
// -----------------------------------------------------------------------------
module tb_mem_write_fsm;

  localparam int N = 8;
  localparam int Z = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tof_dr;
  logic [2:0] tof_index;
  logic       wea;
  logic       adw;
`ifdef MEM_WRITE_OVERRUN_FLAG_EN
  logic       overrun;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_busy;
  int m_idx;
  bit m_pend [N];
  int m_next;
  int m_cnt  [N];
  bit m_adw;
  bit m_ovr;

  // Scenario observation counters
  int cyc = 0;
  int wea_seen;
  int adw_seen;
  int sens5_writes;
  int last_wea_cyc;
  int adw_cyc;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  mem_write_fsm dut (
    .clk              (clk),
    .reset            (reset),
    .ToF_dr           (tof_dr),
    .ToF_Index        (tof_index),
    .wea              (wea),
    .all_data_written (adw)
`ifdef MEM_WRITE_OVERRUN_FLAG_EN
    ,
    .overrun          (overrun)
`endif
  );

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance the reference model across one rising edge. A sensor that is
  // waiting is served in rotation after the one last served; a serve takes
  // one cycle and must be separated from the next by a quiet cycle.
  task automatic modelStep(input logic [7:0] dr, input logic rst);
    bit was_busy;
    bit all_full;
    int c;
    if (rst) begin
      m_busy = 0;
      m_idx  = 0;
      m_next = 0;
      m_adw  = 0;
      m_ovr  = 0;
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0;
        m_cnt[i]  = 0;
      end
    end else begin
      was_busy = m_busy;
      m_adw    = 0;
      for (int i = 0; i < N; i++) begin
        if (dr[i] && m_pend[i] && !(was_busy && m_idx == i)) m_ovr = 1;
      end
      if (was_busy) begin
        m_busy        = 0;
        m_pend[m_idx] = 0;
        if (m_cnt[m_idx] < Z) m_cnt[m_idx]++;
        all_full = 1;
        for (int i = 0; i < N; i++) if (m_cnt[i] != Z) all_full = 0;
        if (all_full) begin
          m_adw = 1;
          for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          c = (m_next + k) % N;
          if (!m_busy && m_pend[c]) begin
            m_busy = 1;
            m_idx  = c;
            m_next = (c + 1) % N;
          end
        end
      end
      for (int i = 0; i < N; i++) if (dr[i]) m_pend[i] = 1;
    end
  endtask

  // Compare every DUT output against the model and update observations.
  task automatic compareAll();
    cyc++;
    checkOutput("wea", wea, m_busy);
    checkOutput("ToF_Index", tof_index, m_idx);
    checkOutput("all_data_written", adw, m_adw);
`ifdef MEM_WRITE_OVERRUN_FLAG_EN
    checkOutput("overrun", overrun, m_ovr);
`endif
    if (wea === 1'b1) begin
      wea_seen++;
      last_wea_cyc = cyc;
      if (tof_index == 3'd5) sens5_writes++;
    end
    if (adw === 1'b1) begin
      adw_seen++;
      adw_cyc = cyc;
    end
  endtask

  // Drive one cycle of inputs (from a falling edge), step the model, and
  // check outputs at the next falling edge.
  task automatic applyStimulus(input logic [7:0] dr, input logic rst);
    tof_dr = dr;
    reset  = rst;
    modelStep(dr, rst);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(8'h00, 1'b0);
  endtask

  task automatic clearObs();
    wea_seen     = 0;
    adw_seen     = 0;
    sens5_writes = 0;
    last_wea_cyc = 0;
    adw_cyc      = 0;
  endtask

  initial begin
    tof_dr = '0;
    reset  = 1'b1;
    clearObs();
    @(negedge clk);

    // Reset state
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'h00, 1'b1);
    checkOutput("reset_wea", wea, 0);
    checkOutput("reset_index", tof_index, 0);
    checkOutput("reset_adw", adw, 0);

    // Single pulse on sensor 2
    applyStimulus(8'h04, 1'b0);
    checkOutput("s025_no_write_yet", wea, 0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("s025_wea", wea, 1);
    checkOutput("s025_index", tof_index, 2);
    applyStimulus(8'h00, 1'b0);
    checkOutput("s025_wea_drop", wea, 0);
    idleCycles(3);

    // All sensors at once after reset: 0..7 in order, every other cycle
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b0);
    for (int j = 0; j < 16; j++) begin
      applyStimulus(8'h00, 1'b0);
      checkOutput("s026_wea_pattern", wea, (j % 2 == 0) ? 1 : 0);
      if (j % 2 == 0) checkOutput("s026_order", tof_index, j / 2);
    end
    idleCycles(4);

    // Full frame: 64 words from each sensor
    applyStimulus(8'h00, 1'b1);
    clearObs();
    repeat (Z) begin
      applyStimulus(8'hFF, 1'b0);
      idleCycles(15);
    end
    idleCycles(10);
    checkOutput("s027_writes", wea_seen, 512);
    checkOutput("s027_frames", adw_seen, 1);
    checkOutput("s027_pulse_timing", adw_cyc - last_wea_cyc, 1);

    // Sensor 3 sends one extra word; counters must have restarted
    clearObs();
    applyStimulus(8'h08, 1'b0);
    idleCycles(3);
    repeat (Z) begin
      applyStimulus(8'hFF, 1'b0);
      idleCycles(15);
    end
    idleCycles(10);
    checkOutput("s028_writes", wea_seen, 513);
    checkOutput("s028_frames", adw_seen, 1);

    // Overrun: sensor 5 pulsed twice while the sequencer is busy
    applyStimulus(8'h00, 1'b1);
    clearObs();
    applyStimulus(8'h03, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h20, 1'b0);
    applyStimulus(8'h20, 1'b0);
    idleCycles(10);
    checkOutput("s029_sensor5_writes", sens5_writes, 1);
`ifdef MEM_WRITE_OVERRUN_FLAG_EN
    checkOutput("s029_overrun_sticky", overrun, 1);
`endif
    applyStimulus(8'h00, 1'b1);
`ifdef MEM_WRITE_OVERRUN_FLAG_EN
    checkOutput("s029_overrun_cleared", overrun, 0);
`endif

    // Reset during a WRITE cycle
    clearObs();
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkOutput("s030_in_write", wea, 1);
    checkOutput("s030_in_write_index", tof_index, 4);
    applyStimulus(8'h00, 1'b1);
    checkOutput("s030_wea_dropped", wea, 0);
    checkOutput("s030_index_zero", tof_index, 0);
    idleCycles(5);
    checkOutput("s030_no_frame_pulse", adw_seen, 0);

    // Random traffic without resets, then with occasional resets
    for (int r = 0; r < 3000; r++) begin
      applyStimulus(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, 1'b0);
    end
    for (int r = 0; r < 1500; r++) begin
      applyStimulus(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                    ($urandom_range(0, 199) == 0));
    end
    idleCycles(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
